// File: rtl/muntjac_pkg.sv
// Shared types for the frontend redirect path: fetch reasons, the buffered
// redirect request and the fixed source indices used by the redirect arbiter.
package muntjac_pkg;

  typedef enum logic [3:0] {
    IF_PREFETCH     = 4'b0000,
    IF_MISPREDICT   = 4'b0001,
    IF_PROT_CHANGED = 4'b0011,
    IF_SATP_CHANGED = 4'b0101,
    IF_FENCE_I      = 4'b0111
  } if_reason_e;

  typedef struct packed {
    if_reason_e  reason;
    logic [63:0] pc;
  } redirect_req_t;

  // Index 0 must stay the trap source: it is the one that preempts the rest.
  localparam int unsigned RedirectSrcTrap       = 0;
  localparam int unsigned RedirectSrcIrq        = 1;
  localparam int unsigned RedirectSrcMispredict = 2;
  localparam int unsigned RedirectSrcFlush      = 3;

endpackage

// File: rtl/muntjac_redirect_slot.sv
// Single-entry pending buffer for one redirect source. Drop beats clear,
// clear beats set, so a trap can discard a request arriving in the same cycle.
module muntjac_redirect_slot
  import muntjac_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_i,
  input  logic          clr_i,
  input  logic          drop_i,
  input  redirect_req_t req_i,
  output logic          valid_o,
  output redirect_req_t req_o
);

  logic          valid_q, valid_d;
  redirect_req_t req_q, req_d;

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (drop_i || clr_i) begin
      valid_d = 1'b0;
    end else if (set_i) begin
      valid_d = 1'b1;
      req_d   = req_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign valid_o = valid_q;
  assign req_o   = req_q;

endmodule

// File: rtl/muntjac_redirect_ctrl.sv
// Fixed-priority arbiter issuing backend redirects to the frontend one at a
// time, with trap preemption and a wrapping sequence id per accepted redirect.
module muntjac_redirect_ctrl
  import muntjac_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned SeqWidth = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic       [NumReq-1:0]       req_valid_i,
  output logic       [NumReq-1:0]       req_ready_o,
  input  if_reason_e [NumReq-1:0]       req_reason_i,
  input  logic       [NumReq-1:0][63:0] req_pc_i,
  output logic                          redirect_valid_o,
  input  logic                          redirect_ready_i,
  output if_reason_e                    redirect_reason_o,
  output logic       [63:0]             redirect_pc_o,
  output logic       [SeqWidth-1:0]     redirect_seq_o,
  output logic                          busy_o
);

  localparam int unsigned SrcW = $clog2(NumReq);

  logic [NumReq-1:0] pend_valid;
  logic [NumReq-1:0] acc;
  logic [NumReq-1:0] cand_valid;
  logic [NumReq-1:0] slot_clr;
  logic [NumReq-1:0] slot_drop;
  redirect_req_t     in_req   [NumReq];
  redirect_req_t     pend_req [NumReq];
  redirect_req_t     cand_req [NumReq];

  logic                out_valid_q, out_valid_d;
  redirect_req_t       out_req_q, out_req_d;
  logic [SrcW-1:0]     out_src_q, out_src_d;
  logic [SeqWidth-1:0] seq_q, seq_d;

  logic            fire;
  logic            trap_acc;
  logic            load;
  logic            any_cand;
  logic [SrcW-1:0] win_idx;

  assign req_ready_o = ~pend_valid;
  assign acc         = req_valid_i & req_ready_o;
  assign fire        = out_valid_q & redirect_ready_i;
  assign trap_acc    = acc[RedirectSrcTrap];
  // A non-trap redirect still waiting at the output is overwritten by a trap.
  assign load        = ~out_valid_q | fire |
                       (trap_acc & (out_src_q != SrcW'(RedirectSrcTrap)));

  for (genvar i = 0; i < NumReq; i++) begin : g_slot
    assign in_req[i].reason = req_reason_i[i];
    assign in_req[i].pc     = req_pc_i[i];
    assign cand_valid[i]    = pend_valid[i] | acc[i];
    assign cand_req[i]      = pend_valid[i] ? pend_req[i] : in_req[i];
    assign slot_clr[i]      = load & any_cand & (win_idx == SrcW'(i));
    assign slot_drop[i]     = (i != RedirectSrcTrap) && trap_acc;

    muntjac_redirect_slot u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .set_i   (acc[i]),
      .clr_i   (slot_clr[i]),
      .drop_i  (slot_drop[i]),
      .req_i   (in_req[i]),
      .valid_o (pend_valid[i]),
      .req_o   (pend_req[i])
    );
  end

  always_comb begin
    any_cand = 1'b0;
    win_idx  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (cand_valid[i] && !any_cand) begin
        any_cand = 1'b1;
        win_idx  = SrcW'(i);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_req_d   = out_req_q;
    out_src_d   = out_src_q;
    seq_d       = seq_q;
    if (fire) begin
      out_valid_d = 1'b0;
      seq_d       = seq_q + SeqWidth'(1);
    end
    if (load && any_cand) begin
      out_valid_d = 1'b1;
      out_req_d   = cand_req[win_idx];
      out_src_d   = win_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      out_src_q   <= '0;
      seq_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_req_q   <= out_req_d;
      out_src_q   <= out_src_d;
      seq_q       <= seq_d;
    end
  end

  assign redirect_valid_o  = out_valid_q;
  assign redirect_reason_o = out_req_q.reason;
  assign redirect_pc_o     = out_req_q.pc;
  assign redirect_seq_o    = seq_q;
  assign busy_o            = out_valid_q | (|pend_valid);

endmodule

// File: doc/muntjac_redirect_ctrl.md
Name: muntjac_redirect_ctrl

Overview:
- Arbitrates redirect requests from several backend sources and issues them one at a time to the frontend redirect port (valid, reason, pc, sequence id).
- Sources are: trap/exception, interrupt, branch mispredict, and fence.i/satp-write flush.
- Buffers one request per source and issues in fixed priority.
- The trap source preempts and discards all other pending redirects.
- A 4-bit sequence id increments per issued redirect, so the frontend (or the RVFI-DII harness) can tag fetches.

Parameters:
- NumReq, 4, number of requesters; index 0 is highest priority and is the preempting (trap) source; must be >= 2.
- SeqWidth, 4, width of the redirect sequence counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  NumReq  per-source redirect request
- req_ready_o  out  NumReq  per-source slot can accept
- req_reason_i  in  NumReq x if_reason_e  redirect reason per source
- req_pc_i  in  NumReq x 64  target pc per source
- redirect_valid_o  out  1  redirect presented to frontend
- redirect_ready_i  in  1  frontend/harness accepts redirect
- redirect_reason_o  out  if_reason_e  reason of presented redirect
- redirect_pc_o  out  64  target pc
- redirect_seq_o  out  SeqWidth  id of the most recently accepted redirect
- busy_o  out  1  any pending slot or output valid

Behaviour:
- Reset (async, immediate):
  - all pending slots empty; output register empty.
  - redirect_valid_o=0, redirect_pc_o=0, redirect_reason_o=0, redirect_seq_o=0, busy_o=0.
  - req_ready_o = all ones.
- Storage: one pending slot per source {valid, reason, pc}, plus one output register {valid, reason, pc, src_idx}.
- Source handshake: req_ready_o[i] = ~pending[i].valid.
  - Acceptance happens when valid & ready. Ready does not depend on valid.
- Output handshake:
  - Fire = redirect_valid_o & redirect_ready_i.
  - While valid and not fired, reason, pc and src_idx are held stable, except for trap preemption (below).
- Load candidates each cycle: pending slots plus this cycle's accepted requests. A slot already pending masks the new request from that source; it cannot be accepted anyway.
- Load rule: if the output register is empty or fires this cycle, the lowest-index candidate is loaded into it.
  - Losing candidates are written to (or stay in) their pending slots; the winner's slot is cleared.
  - Latency: a request accepted at cycle t with no competition drives redirect_valid_o=1 at t+1.
- Trap preemption: when source 0 is accepted at cycle t:
  - all pending slots 1..NumReq-1 clear at t+1 (those requests are dropped; their ready rises at t+1).
  - if the output register holds src_idx != 0 and does not fire at t, it is overwritten with the source-0 request at t+1.
  - if the output does fire at t, that redirect completes normally, and the source-0 request loads at t+1.
  - If pending[0] is already valid, source 0 is not ready and no preemption occurs until it drains.
- Sequence: redirect_seq_o increments by 1 on each fire, visible the cycle after fire. It wraps modulo 2^SeqWidth (15 -> 0 at default). It does not change on preemption or drop.
- busy_o = output valid | any pending valid.
- Simultaneous accept of sources 1..3 with output empty: source 1 issues first, then 2, then 3. One per cycle if redirect_ready_i stays high.
- Reset mid-operation: all state is discarded immediately; no redirect is issued for dropped requests.

Decomposition:
- muntjac_pkg:
  - redirect_req_t struct {if_reason_e reason; logic [63:0] pc}.
  - localparam RedirectSrcTrap=0, RedirectSrcIrq=1, RedirectSrcMispredict=2, RedirectSrcFlush=3.
  - if_reason_e is reused unchanged.
- One sub-module, muntjac_redirect_slot: a single-entry buffer with set/clear/drop inputs, instantiated NumReq times.
- Fixed-priority selection and the sequence counter stay in the top level.

Test Plan:
- Single request: src2 valid, pc=0x8000_1000, redirect_ready_i=1 at t → redirect_valid_o=1, pc=0x8000_1000 at t+1; seq 0→1 at t+2; busy_o=0 at t+2.
- Simultaneous: src1 pc=0x100, src2 pc=0x200, src3 pc=0x300 accepted at t, ready held 1 → outputs 0x100, 0x200, 0x300 at t+1, t+2, t+3; seq ends at 3.
- Backpressure: redirect_ready_i=0 for 5 cycles with src2 output pc=0x200 → pc/reason stable; req_ready_o[2]=1, then a second src2 request fills the slot and req_ready_o[2]=0 until drain.
- Preemption: src2 output held (ready=0), src3 pending, src0 pc=0xFFFF_0000 accepted at t → at t+1 output pc=0xFFFF_0000, pending[3] cleared; after fire only one redirect issued, seq +1.
- Fire-and-trap same cycle: src2 fires at t while src0 is accepted → src2 counted (seq+1), src0 output at t+1, seq+2 after its fire.
- Wrap and reset: 16 fires → redirect_seq_o=0. Asserting rst_i mid-hold → redirect_valid_o=0, busy_o=0 immediately, req_ready_o all ones.
